// File: rtl/mult_seq_ctrl_if.sv
// Request/response valid-ready bundle between the multiplier sequencer
// and its upstream producer / downstream consumer.
interface mult_seq_ctrl_if;
    logic req_valid;
    logic req_ready;
    logic rsp_valid;
    logic rsp_ready;

    modport master (
        output req_valid,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid
    );

    modport slave (
        input  req_valid,
        input  rsp_ready,
        output req_ready,
        output rsp_valid
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 4-bit add-and-shift multiplier datapath.
// Define MULT_SEQ_CTRL_ABORT_EN to add an abort input for LOAD/STEP.
module mult_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic           clk,
    input  logic           reset,
`ifdef MULT_SEQ_CTRL_ABORT_EN
    input  logic           abort,
`endif
    mult_seq_ctrl_if.slave hs,
    input  logic           p0,
    output logic           mc_a_en,
    output logic           mc_start,
    output logic           mc_clr,
    output logic           mc_ld,
    output logic           mc_add_sel,
    output logic           busy,
    output logic [CW-1:0]  step_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            load_q;
    logic            ld_q;
    logic            busy_q;
    logic            kill;

`ifdef MULT_SEQ_CTRL_ABORT_EN
    assign kill = abort & ((state_q == LOAD) | (state_q == STEP));
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hs.req_valid) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                state_d = STEP;
                cnt_d   = '0;
            end
            STEP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (hs.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state so they change only
    // on clock edges and stay low while reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            load_q      <= 1'b0;
            ld_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == DONE);
            load_q      <= (state_d == LOAD);
            ld_q        <= (state_d == STEP);
            busy_q      <= (state_d == LOAD) | (state_d == STEP);
        end
    end

    assign hs.req_ready = req_ready_q;
    assign hs.rsp_valid = rsp_valid_q;
    assign mc_a_en      = load_q;
    assign mc_start     = load_q;
    assign mc_clr       = load_q;
    assign mc_ld        = ld_q;
    assign busy         = busy_q;
    assign step_cnt     = cnt_q;

    // Follows the live multiplier bit so the adder sees it this cycle.
    assign mc_add_sel   = p0 & (state_q == STEP);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl driving a behavioural copy of the
// add-and-shift datapath; expected products are hand-computed.
module tb_mult_seq_ctrl;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          p0;
    logic          mc_a_en;
    logic          mc_start;
    logic          mc_clr;
    logic          mc_ld;
    logic          mc_add_sel;
    logic          busy;
    logic [CW-1:0] step_cnt;
`ifdef MULT_SEQ_CTRL_ABORT_EN
    logic          abort;
`endif

    logic [3:0]    a_in;
    logic [3:0]    b_in;
    logic [3:0]    a_q;
    logic [8:0]    p_q;
    logic [4:0]    sum;

    int n_chk;
    int n_fail;

    mult_seq_ctrl_if hs ();

    mult_seq_ctrl #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
`ifdef MULT_SEQ_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .hs         (hs.slave),
        .p0         (p0),
        .mc_a_en    (mc_a_en),
        .mc_start   (mc_start),
        .mc_clr     (mc_clr),
        .mc_ld      (mc_ld),
        .mc_add_sel (mc_add_sel),
        .busy       (busy),
        .step_cnt   (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: multiplicand register, {carry, high, low} product register.
    assign sum = {1'b0, p_q[7:4]} + {1'b0, (mc_add_sel ? a_q : 4'd0)};
    assign p0  = p_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            p_q <= '0;
        end else begin
            if (mc_a_en) a_q <= a_in;
            if (mc_start) p_q[3:0] <= b_in;
            if (mc_clr) p_q[8:4] <= '0;
            if (mc_ld) p_q <= {1'b0, sum, p_q[3:1]};
        end
    end

    typedef struct {
        string      nm;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        logic [3:0] sel;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] mc_bits();
        return {mc_a_en, mc_start, mc_clr, mc_ld};
    endfunction

    // Call at a negedge with the controller idle.
    task automatic run_op(input vec_t v);
        int         got;
        int         k;
        int         nbusy;
        int         nstart;
        int         nld;
        int         excl;
        logic [3:0] sel;
        got    = -1;
        k      = 0;
        nbusy  = 0;
        nstart = 0;
        nld    = 0;
        excl   = 0;
        sel    = '0;
        a_in   = v.a;
        b_in   = v.b;
        hs.rsp_ready = 1'b1;
        hs.req_valid = 1'b1;
        check({v.nm, " req_ready idle"}, 32'(hs.req_ready), 1);
        @(posedge clk);
        for (int n = 1; n <= 20 && got < 0; n++) begin
            @(negedge clk);
            if (n == 1) hs.req_valid = 1'b0;
            if (mc_start && mc_ld) excl++;
            nbusy  += int'(busy);
            nstart += int'(mc_start);
            nld    += int'(mc_ld);
            if (mc_ld && k < 4) begin
                sel[k] = mc_add_sel;
                k++;
            end
            if (hs.rsp_valid) got = n;
        end
        check({v.nm, " latency"}, 32'(got), 6);
        check({v.nm, " product"}, 32'(p_q[7:0]), 32'(v.prod));
        check({v.nm, " step_cnt"}, 32'(step_cnt), 4);
        check({v.nm, " add_sel"}, 32'(sel), 32'(v.sel));
        check({v.nm, " busy cyc"}, 32'(nbusy), 5);
        check({v.nm, " start cyc"}, 32'(nstart), 1);
        check({v.nm, " ld cyc"}, 32'(nld), 4);
        check({v.nm, " excl"}, 32'(excl), 0);
        @(negedge clk);
        check({v.nm, " req_ready after"}, 32'(hs.req_ready), 1);
        check({v.nm, " rsp_valid after"}, 32'(hs.rsp_valid), 0);
    endtask

    // Starts an op and stops at the negedge where step_cnt==s in STEP.
    task automatic start_until_step(input logic [3:0] a, input logic [3:0] b,
                                    input int s, output int ok);
        ok   = 0;
        a_in = a;
        b_in = b;
        hs.req_valid = 1'b1;
        for (int n = 0; n < 12 && ok == 0; n++) begin
            @(negedge clk);
            hs.req_valid = 1'b0;
            if (mc_ld && int'(step_cnt) == s) ok = 1;
        end
    endtask

    initial begin
        int acc;
        int nr;
        int ok;
        int seen;
        int acc_t[2];
        logic [7:0] prods[2];

        n_chk  = 0;
        n_fail = 0;
        vecs[0] = '{"3x5",   4'd3,  4'd5,  8'd15,  4'b0101};
        vecs[1] = '{"15x15", 4'd15, 4'd15, 8'd225, 4'b1111};
        vecs[2] = '{"0x9",   4'd0,  4'd9,  8'd0,   4'b1001};
        vecs[3] = '{"13x11", 4'd13, 4'd11, 8'd143, 4'b1011};
        vecs[4] = '{"15x0",  4'd15, 4'd0,  8'd0,   4'b0000};
        vecs[5] = '{"1x8",   4'd1,  4'd8,  8'd8,   4'b1000};

        rst_n        = 1'b0;
        hs.req_valid = 1'b0;
        hs.rsp_ready = 1'b0;
        a_in         = '0;
        b_in         = '0;
`ifdef MULT_SEQ_CTRL_ABORT_EN
        abort        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(hs.req_ready), 0);
        check("rst rsp_valid", 32'(hs.rsp_valid), 0);
        check("rst mc", 32'(mc_bits()), 0);
        check("rst busy", 32'(busy), 0);
        check("rst step_cnt", 32'(step_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("rel req_ready", 32'(hs.req_ready), 0);
        @(negedge clk);
        check("rel req_ready edge", 32'(hs.req_ready), 1);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Back-to-back with req_valid held high.
        acc = 0;
        nr  = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        prods[0] = '0;
        prods[1] = '0;
        a_in = 4'd2;
        b_in = 4'd7;
        hs.rsp_ready = 1'b1;
        hs.req_valid = 1'b1;
        for (int c = 0; c < 40 && nr < 2; c++) begin
            if (hs.req_valid && hs.req_ready && acc < 2) begin
                acc_t[acc] = c;
                acc++;
            end
            if (hs.rsp_valid) begin
                prods[nr] = p_q[7:0];
                nr++;
            end
            @(negedge clk);
            if (acc == 1 && c == acc_t[0] + 2) begin
                a_in = 4'd6;
                b_in = 4'd6;
            end
            if (acc == 2) hs.req_valid = 1'b0;
        end
        check("b2b count", 32'(nr), 2);
        check("b2b prod0", 32'(prods[0]), 14);
        check("b2b prod1", 32'(prods[1]), 36);
        check("b2b spacing", 32'(acc_t[1] - acc_t[0]), 7);
        hs.req_valid = 1'b0;
        @(negedge clk);

        // Backpressure, with a new request arriving while DONE stalls.
        a_in = 4'd7;
        b_in = 4'd9;
        hs.rsp_ready = 1'b0;
        hs.req_valid = 1'b1;
        seen = 0;
        for (int n = 0; n < 12 && seen == 0; n++) begin
            @(negedge clk);
            if (n == 1) hs.req_valid = 1'b0;
            if (hs.rsp_valid) seen = 1;
        end
        check("bp done", 32'(seen), 1);
        a_in = 4'd5;
        b_in = 4'd5;
        hs.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp rsp_valid", 32'(hs.rsp_valid), 1);
            check("bp product", 32'(p_q[7:0]), 63);
            check("bp mc", 32'(mc_bits()), 0);
            check("bp req_ready", 32'(hs.req_ready), 0);
            check("bp step_cnt", 32'(step_cnt), 4);
        end
        hs.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp idle rsp_valid", 32'(hs.rsp_valid), 0);
        check("bp idle req_ready", 32'(hs.req_ready), 1);
        @(negedge clk);
        hs.req_valid = 1'b0;
        check("bp load start", 32'(mc_start), 1);
        check("bp load busy", 32'(busy), 1);
        seen = 0;
        for (int n = 0; n < 12 && seen == 0; n++) begin
            @(negedge clk);
            if (hs.rsp_valid) seen = 1;
        end
        check("bp next done", 32'(seen), 1);
        check("bp next product", 32'(p_q[7:0]), 25);
        @(negedge clk);

        // Asynchronous reset during the second STEP cycle.
        start_until_step(4'd9, 4'd9, 1, ok);
        check("rst2 reached step", 32'(ok), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2 mc", 32'(mc_bits()), 0);
        check("rst2 busy", 32'(busy), 0);
        check("rst2 req_ready", 32'(hs.req_ready), 0);
        check("rst2 rsp_valid", 32'(hs.rsp_valid), 0);
        check("rst2 step_cnt", 32'(step_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        @(negedge clk);
        check("rst2 req_ready edge", 32'(hs.req_ready), 1);
        for (int n = 0; n < 6; n++) begin
            if (hs.rsp_valid) seen = 1;
            @(negedge clk);
        end
        check("rst2 no rsp", 32'(seen), 0);
        run_op('{"4x4", 4'd4, 4'd4, 8'd16, 4'b0100});

`ifdef MULT_SEQ_CTRL_ABORT_EN
        start_until_step(4'd6, 4'd5, 2, ok);
        check("abort reached step", 32'(ok), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort req_ready", 32'(hs.req_ready), 1);
        check("abort busy", 32'(busy), 0);
        check("abort mc", 32'(mc_bits()), 0);
        check("abort step_cnt", 32'(step_cnt), 0);
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            if (hs.rsp_valid) seen = 1;
            @(negedge clk);
        end
        check("abort no rsp", 32'(seen), 0);

        a_in = 4'd3;
        b_in = 4'd7;
        hs.rsp_ready = 1'b0;
        hs.req_valid = 1'b1;
        seen = 0;
        for (int n = 0; n < 12 && seen == 0; n++) begin
            @(negedge clk);
            hs.req_valid = 1'b0;
            if (hs.rsp_valid) seen = 1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort done rsp", 32'(hs.rsp_valid), 1);
        check("abort done prod", 32'(p_q[7:0]), 21);
        hs.rsp_ready = 1'b1;
        @(negedge clk);
        check("abort done idle", 32'(hs.req_ready), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
